// File: rtl/lsu_align_unit_if.sv
// Bundle of core-request and data-bus signals for the load/store alignment unit.
// The slave modport is the alignment unit itself; the master modport is the
// environment around it: the core issuing requests and the memory answering beats.
interface lsu_align_unit_if #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
);
   // core request / response
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [2:0]        req_funct3;
   logic [ADDR_W-1:0] req_addr;
   logic [XLEN-1:0]   req_wdata;
   logic              rsp_valid;
   logic [XLEN-1:0]   rsp_rdata;
   logic              rsp_err;
   // data-memory bus
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [XLEN/8-1:0] mem_be;
   logic [XLEN-1:0]   mem_wdata;
   logic              mem_gnt;
   logic              mem_rvalid;
   logic [XLEN-1:0]   mem_rdata;

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      input  mem_gnt, mem_rvalid, mem_rdata
   );

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      output mem_gnt, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/lsu_align_unit.sv
// Load/store alignment: byte enables, lane shifting, load extension, split of straddling accesses.
// Latency: aligned 3 cycles accept->rsp_valid, split 5, rejected 1; +1 per gnt stall / rvalid delay.
// Backpressure: req_ready only in IDLE; mem beat held until mem_gnt; rsp_valid has no backpressure.
//
// Ports: clk, rst_n (synchronous, active low); bus (slave side of lsu_align_unit_if):
//   req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata  core request
//   rsp_valid/rsp_rdata/rsp_err                               one-cycle completion
//   mem_req/mem_we/mem_addr/mem_be/mem_wdata/mem_gnt/mem_rvalid/mem_rdata  data bus
module lsu_align_unit #(
   parameter int XLEN             = 32,
   parameter int ADDR_W           = 32,
   parameter int ALLOW_MISALIGNED = 1
) (
   input logic             clk,
   input logic             rst_n,
   lsu_align_unit_if.slave bus
);
   localparam int NB = XLEN / 8;
   localparam int OB = $clog2(NB);

   typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;

   state_t            state_q, state_d;
   logic              we_q;
   logic [2:0]        f3_q;
   logic [ADDR_W-1:0] addr_q;
   logic [XLEN-1:0]   wdata_q;
   logic [XLEN-1:0]   merge_q;
   logic              err_q;

   // Lane mask of an access of the given size, sized to two bus words so that
   // shifting it by the offset yields beat 0 (low half) and beat 1 (high half).
   function automatic logic [2*NB-1:0] size_mask(input logic [1:0] size);
      case (size)
         2'd0:    return (2*NB)'(1);
         2'd1:    return (2*NB)'(3);
         2'd2:    return (2*NB)'(15);
         default: return (2*NB)'(255);
      endcase
   endfunction

   function automatic logic straddles(input logic [OB-1:0] o, input logic [1:0] size);
      logic [4:0] last;
      last = 5'(o) + (5'd1 << size);
      return last > 5'(NB);
   endfunction

   logic accept, req_err;
   assign accept  = bus.req_valid && (state_q == IDLE);
   assign req_err = ((bus.req_funct3[1:0] == 2'b11) && (XLEN == 32)) ||
                    ((ALLOW_MISALIGNED == 0) && straddles(bus.req_addr[OB-1:0], bus.req_funct3[1:0]));

   // Beat geometry derived from the latched request.
   logic [OB-1:0]     o;
   logic [1:0]        size;
   logic              split;
   logic [OB:0]       hi_sh;       // NB - o: byte shift that lines beat 1 up behind beat 0
   logic [2*NB-1:0]   size_m;
   logic [2*NB-1:0]   be_wide;
   logic [2*XLEN-1:0] wdata_wide;
   logic [ADDR_W-1:0] beat0_addr;

   assign o          = addr_q[OB-1:0];
   assign size       = f3_q[1:0];
   assign split      = straddles(o, size);
   assign hi_sh      = (OB+1)'(NB) - (OB+1)'(o);
   assign size_m     = size_mask(size);
   assign be_wide    = size_m << o;
   assign wdata_wide = {{XLEN{1'b0}}, wdata_q} << {o, 3'b000};
   assign beat0_addr = addr_q & ~ADDR_W'(NB - 1);

   // Sign/zero extension of the low n bytes of the merged load word.
   logic            fill;
   logic [XLEN-1:0] ext_data;
   always_comb begin
      fill     = 1'b0;
      ext_data = '0;
      case (size)
         2'd0:    fill = merge_q[7];
         2'd1:    fill = merge_q[15];
         2'd2:    fill = merge_q[31];
         default: fill = merge_q[XLEN-1];
      endcase
      fill = fill & ~f3_q[2];
      for (int i = 0; i < NB; i++)
         ext_data[8*i +: 8] = size_m[i] ? merge_q[8*i +: 8] : {8{fill}};
   end

   always_comb begin
      state_d        = state_q;
      bus.req_ready  = 1'b0;
      bus.rsp_valid  = 1'b0;
      bus.rsp_err    = 1'b0;
      bus.rsp_rdata  = '0;
      bus.mem_req    = 1'b0;
      bus.mem_we     = 1'b0;
      bus.mem_addr   = '0;
      bus.mem_be     = '0;
      bus.mem_wdata  = '0;
      case (state_q)
         IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) state_d = req_err ? RESP : REQ0;
         end
         REQ0: begin
            bus.mem_req   = 1'b1;
            bus.mem_we    = we_q;
            bus.mem_addr  = beat0_addr;
            bus.mem_be    = be_wide[NB-1:0];
            bus.mem_wdata = wdata_wide[XLEN-1:0];
            if (bus.mem_gnt) state_d = WAIT0;
         end
         WAIT0: if (bus.mem_rvalid) state_d = split ? REQ1 : RESP;
         REQ1: begin
            bus.mem_req   = 1'b1;
            bus.mem_we    = we_q;
            bus.mem_addr  = beat0_addr + ADDR_W'(NB);
            bus.mem_be    = be_wide[2*NB-1:NB];
            bus.mem_wdata = wdata_wide[2*XLEN-1:XLEN];
            if (bus.mem_gnt) state_d = WAIT1;
         end
         WAIT1: if (bus.mem_rvalid) state_d = RESP;
         RESP: begin
            bus.rsp_valid = 1'b1;
            bus.rsp_err   = err_q;
            bus.rsp_rdata = (err_q || we_q) ? '0 : ext_data;
            state_d       = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         f3_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         merge_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            we_q    <= bus.req_we;
            f3_q    <= bus.req_funct3;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            err_q   <= req_err;
            merge_q <= '0;
         end
         // Store completions carry no data; only loads fold beats into the merge word.
         if (state_q == WAIT0 && bus.mem_rvalid && !we_q)
            merge_q <= merge_q | (bus.mem_rdata >> {o, 3'b000});
         if (state_q == WAIT1 && bus.mem_rvalid && !we_q)
            merge_q <= merge_q | (bus.mem_rdata << {hi_sh, 3'b000});
      end
   end
endmodule

// File: tb/tb_lsu_align_unit.sv
module tb_lsu_align_unit;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   int   total = 0;
   int   bad   = 0;
   int   cyc_cnt = 0;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // stimulus variables; sel_v picks the DUT that gets valid/gnt/rvalid
   logic        sel_v, valid_v, we_v, gnt_v, rv_v;
   logic [2:0]  f3_v;
   logic [31:0] addr_v, wdata_v, rd_v;

   lsu_align_unit_if #(.XLEN(32), .ADDR_W(32)) bus_a ();
   lsu_align_unit_if #(.XLEN(32), .ADDR_W(32)) bus_b ();

   assign bus_a.req_valid  = valid_v & ~sel_v;
   assign bus_b.req_valid  = valid_v & sel_v;
   assign bus_a.mem_gnt    = gnt_v & ~sel_v;
   assign bus_b.mem_gnt    = gnt_v & sel_v;
   assign bus_a.mem_rvalid = rv_v & ~sel_v;
   assign bus_b.mem_rvalid = rv_v & sel_v;
   assign bus_a.req_we     = we_v;
   assign bus_b.req_we     = we_v;
   assign bus_a.req_funct3 = f3_v;
   assign bus_b.req_funct3 = f3_v;
   assign bus_a.req_addr   = addr_v;
   assign bus_b.req_addr   = addr_v;
   assign bus_a.req_wdata  = wdata_v;
   assign bus_b.req_wdata  = wdata_v;
   assign bus_a.mem_rdata  = rd_v;
   assign bus_b.mem_rdata  = rd_v;

   lsu_align_unit #(.XLEN(32), .ADDR_W(32), .ALLOW_MISALIGNED(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(bus_a));
   lsu_align_unit #(.XLEN(32), .ADDR_W(32), .ALLOW_MISALIGNED(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(bus_b));

   typedef struct {
      int          lat;
      int          nbeats;
      int          acc;
      logic        rdy;
      logic        unstable;
      logic [31:0] addr0, addr1, wd0, wd1, rdata;
      logic [3:0]  be0, be1;
      logic        we0, err;
   } res_t;

   // Issues one request and plays the memory: `stall` gnt-low cycles per beat,
   // rvalid one cycle after each grant. Records what the bus saw; does no checking.
   task automatic do_access(input logic sel, input logic we, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rd0, input logic [31:0] rd1,
                            input int stall, output res_t r);
      int   cyc, stall_left, pend_beat;
      logic pending, prev_req, m_req, done;
      logic [31:0] c_addr, c_wd;
      logic [3:0]  c_be;
      r = '{lat: -1, nbeats: 0, acc: 0, rdy: 0, unstable: 0, addr0: 0, addr1: 0,
            wd0: 0, wd1: 0, rdata: 0, be0: 0, be1: 0, we0: 0, err: 0};
      @(negedge clk);
      sel_v = sel; we_v = we; f3_v = f3; addr_v = addr; wdata_v = wdata;
      r.rdy = sel ? bus_b.req_ready : bus_a.req_ready;
      r.acc = cyc_cnt;
      valid_v = 1'b1;
      cyc = 0; stall_left = stall; pending = 0; pend_beat = 0; prev_req = 0; done = 0;
      while (!done && cyc < 60) begin
         @(negedge clk);
         cyc++;
         valid_v = 1'b0;
         rv_v    = 1'b0;
         if (pending) begin
            rv_v = 1'b1;
            rd_v = (pend_beat == 0) ? rd0 : rd1;
            pending = 0;
         end
         m_req  = sel ? bus_b.mem_req   : bus_a.mem_req;
         c_addr = sel ? bus_b.mem_addr  : bus_a.mem_addr;
         c_be   = sel ? bus_b.mem_be    : bus_a.mem_be;
         c_wd   = sel ? bus_b.mem_wdata : bus_a.mem_wdata;
         if (m_req) begin
            if (!prev_req) begin
               if (r.nbeats == 0) begin
                  r.addr0 = c_addr; r.be0 = c_be; r.wd0 = c_wd;
                  r.we0 = sel ? bus_b.mem_we : bus_a.mem_we;
               end else if (r.nbeats == 1) begin
                  r.addr1 = c_addr; r.be1 = c_be; r.wd1 = c_wd;
               end else r.unstable = 1'b1;
               r.nbeats++;
            end else if ((r.nbeats == 1 && {c_addr, c_be, c_wd} != {r.addr0, r.be0, r.wd0}) ||
                         (r.nbeats == 2 && {c_addr, c_be, c_wd} != {r.addr1, r.be1, r.wd1}))
               r.unstable = 1'b1;
            if (stall_left > 0) begin
               gnt_v = 1'b0;
               stall_left--;
            end else begin
               gnt_v = 1'b1;
               pending = 1;
               pend_beat = r.nbeats - 1;
               stall_left = stall;
            end
         end else gnt_v = 1'b0;
         prev_req = m_req;
         if (sel ? bus_b.rsp_valid : bus_a.rsp_valid) begin
            r.lat   = cyc;
            r.rdata = sel ? bus_b.rsp_rdata : bus_a.rsp_rdata;
            r.err   = sel ? bus_b.rsp_err : bus_a.rsp_err;
            done = 1;
         end
      end
      gnt_v = 1'b0;
      rv_v  = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      total++; if (bus_a.req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", bus_a.req_ready); end
      total++; if ({bus_a.mem_req, bus_a.rsp_valid, bus_a.rsp_err, bus_a.mem_we} !== 4'b0) begin bad++;
         $display("FAIL reset_ctrl: got req/rsp/err/we=%b want 0000", {bus_a.mem_req, bus_a.rsp_valid, bus_a.rsp_err, bus_a.mem_we}); end
      total++; if ({bus_a.mem_addr, bus_a.mem_be, bus_a.mem_wdata, bus_a.rsp_rdata} !== '0) begin bad++;
         $display("FAIL reset_data: addr=%h be=%b wdata=%h rdata=%h want all 0", bus_a.mem_addr, bus_a.mem_be, bus_a.mem_wdata, bus_a.rsp_rdata); end
      total++; if ({bus_b.req_ready, bus_b.mem_req, bus_b.rsp_valid} !== 3'b100) begin bad++;
         $display("FAIL reset_b: got ready/req/rsp=%b want 100", {bus_b.req_ready, bus_b.mem_req, bus_b.rsp_valid}); end
      rst_n = 1'b1;
   endtask

   task automatic test_aligned_load();
      res_t r;
      do_access(0, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 32'h0, 0, r);
      total++; if (r.rdy !== 1'b1) begin bad++; $display("FAIL lw_ready: got %b want 1", r.rdy); end
      total++; if (r.lat !== 3) begin bad++; $display("FAIL lw_latency: got %0d want 3", r.lat); end
      total++; if (r.nbeats !== 1) begin bad++; $display("FAIL lw_beats: got %0d want 1", r.nbeats); end
      total++; if (r.addr0 !== 32'h100 || r.be0 !== 4'b1111 || r.we0 !== 1'b0) begin bad++;
         $display("FAIL lw_beat0: addr=%h be=%b we=%b want 00000100 1111 0", r.addr0, r.be0, r.we0); end
      total++; if (r.rdata !== 32'hDEADBEEF || r.err !== 1'b0) begin bad++;
         $display("FAIL lw_rdata: got %h err=%b want deadbeef err=0", r.rdata, r.err); end
      do_access(0, 0, 3'b000, 32'h103, 32'h0, 32'h80000000, 32'h0, 0, r);
      total++; if (r.addr0 !== 32'h100 || r.be0 !== 4'b1000) begin bad++;
         $display("FAIL lb_beat0: addr=%h be=%b want 00000100 1000", r.addr0, r.be0); end
      total++; if (r.rdata !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_sext: got %h want ffffff80", r.rdata); end
      do_access(0, 0, 3'b100, 32'h103, 32'h0, 32'h80000000, 32'h0, 0, r);
      total++; if (r.rdata !== 32'h00000080) begin bad++; $display("FAIL lbu_zext: got %h want 00000080", r.rdata); end
      do_access(0, 0, 3'b001, 32'h102, 32'h0, 32'h8001_7FFF, 32'h0, 0, r);
      total++; if (r.be0 !== 4'b1100 || r.rdata !== 32'hFFFF8001) begin bad++;
         $display("FAIL lh_hi: be=%b rdata=%h want 1100 ffff8001", r.be0, r.rdata); end
   endtask

   task automatic test_store();
      res_t r;
      do_access(0, 1, 3'b001, 32'h102, 32'h1234ABCD, 32'hFFFFFFFF, 32'h0, 0, r);
      total++; if (r.be0 !== 4'b1100 || r.addr0 !== 32'h100) begin bad++;
         $display("FAIL sh_be: addr=%h be=%b want 00000100 1100", r.addr0, r.be0); end
      total++; if (r.wd0 !== 32'hABCD0000 || r.we0 !== 1'b1) begin bad++;
         $display("FAIL sh_wdata: wdata=%h we=%b want abcd0000 1", r.wd0, r.we0); end
      total++; if (r.rdata !== 32'h0 || r.lat !== 3) begin bad++;
         $display("FAIL sh_rsp: rdata=%h lat=%0d want 0 3", r.rdata, r.lat); end
      do_access(0, 1, 3'b010, 32'h105, 32'hA1B2C3D4, 32'h0, 32'h0, 0, r);
      total++; if ({r.be0, r.wd0, r.be1, r.wd1} !== {4'b1110, 32'hB2C3D400, 4'b0001, 32'h000000A1}) begin bad++;
         $display("FAIL sw_split: be0=%b wd0=%h be1=%b wd1=%h want 1110 b2c3d400 0001 000000a1", r.be0, r.wd0, r.be1, r.wd1); end
   endtask

   task automatic test_split();
      res_t r;
      do_access(0, 0, 3'b010, 32'h103, 32'h0, 32'h11223344, 32'h55667788, 0, r);
      total++; if (r.nbeats !== 2) begin bad++; $display("FAIL split_beats: got %0d want 2", r.nbeats); end
      total++; if (r.addr0 !== 32'h100 || r.be0 !== 4'b1000) begin bad++;
         $display("FAIL split_beat0: addr=%h be=%b want 00000100 1000", r.addr0, r.be0); end
      total++; if (r.addr1 !== 32'h104 || r.be1 !== 4'b0111) begin bad++;
         $display("FAIL split_beat1: addr=%h be=%b want 00000104 0111", r.addr1, r.be1); end
      total++; if (r.rdata !== 32'h66778811) begin bad++; $display("FAIL split_rdata: got %h want 66778811", r.rdata); end
      total++; if (r.lat !== 5) begin bad++; $display("FAIL split_latency: got %0d want 5", r.lat); end
      do_access(0, 0, 3'b010, 32'h103, 32'h0, 32'h11223344, 32'h55667788, 3, r);
      total++; if (r.lat !== 11) begin bad++; $display("FAIL stall_latency: got %0d want 11", r.lat); end
      total++; if (r.rdata !== 32'h66778811 || r.unstable !== 1'b0) begin bad++;
         $display("FAIL stall_data: rdata=%h unstable=%b want 66778811 0", r.rdata, r.unstable); end
   endtask

   task automatic test_errors();
      res_t r;
      do_access(1, 0, 3'b001, 32'h103, 32'h0, 32'h0, 32'h0, 0, r);
      total++; if (r.lat !== 1 || r.err !== 1'b1 || r.nbeats !== 0 || r.rdata !== 32'h0) begin bad++;
         $display("FAIL nomis_lh_err: lat=%0d err=%b beats=%0d rdata=%h want 1 1 0 0", r.lat, r.err, r.nbeats, r.rdata); end
      // a halfword at offset 1 fits inside one bus word, so it is not rejected
      do_access(1, 0, 3'b001, 32'h101, 32'h0, 32'h00ABCD00, 32'h0, 0, r);
      total++; if (r.err !== 1'b0 || r.be0 !== 4'b0110 || r.rdata !== 32'hFFFFABCD) begin bad++;
         $display("FAIL nomis_lh_ok: err=%b be=%b rdata=%h want 0 0110 ffffabcd", r.err, r.be0, r.rdata); end
      do_access(1, 0, 3'b011, 32'h100, 32'h0, 32'h0, 32'h0, 0, r);
      total++; if (r.lat !== 1 || r.err !== 1'b1 || r.nbeats !== 0) begin bad++;
         $display("FAIL nomis_ld_err: lat=%0d err=%b beats=%0d want 1 1 0", r.lat, r.err, r.nbeats); end
      do_access(0, 0, 3'b011, 32'h100, 32'h0, 32'h0, 32'h0, 0, r);
      total++; if (r.lat !== 1 || r.err !== 1'b1 || r.nbeats !== 0) begin bad++;
         $display("FAIL ld_on_32_err: lat=%0d err=%b beats=%0d want 1 1 0", r.lat, r.err, r.nbeats); end
   endtask

   task automatic test_reset_mid();
      res_t r;
      logic pulse;
      @(negedge clk);
      sel_v = 0; we_v = 0; f3_v = 3'b010; addr_v = 32'h103; valid_v = 1'b1;
      @(negedge clk); valid_v = 1'b0; gnt_v = 1'b1;                       // REQ0
      @(negedge clk); gnt_v = 1'b0; rv_v = 1'b1; rd_v = 32'h11223344;    // WAIT0
      @(negedge clk); rv_v = 1'b0; gnt_v = 1'b1;                         // REQ1
      total++; if (bus_a.mem_req !== 1'b1 || bus_a.mem_addr !== 32'h104) begin bad++;
         $display("FAIL rstmid_req1: req=%b addr=%h want 1 00000104", bus_a.mem_req, bus_a.mem_addr); end
      @(negedge clk); gnt_v = 1'b0; rst_n = 1'b0;                        // WAIT1
      @(negedge clk); rst_n = 1'b1; rv_v = 1'b1; rd_v = 32'h55667788;    // late rvalid
      total++; if (bus_a.mem_req !== 1'b0 || bus_a.req_ready !== 1'b1) begin bad++;
         $display("FAIL rstmid_idle: req=%b ready=%b want 0 1", bus_a.mem_req, bus_a.req_ready); end
      pulse = bus_a.rsp_valid;
      repeat (4) begin
         @(negedge clk); rv_v = 1'b0;
         pulse = pulse | bus_a.rsp_valid | bus_a.mem_req;
      end
      total++; if (pulse !== 1'b0 || bus_a.req_ready !== 1'b1) begin bad++;
         $display("FAIL rstmid_quiet: activity=%b ready=%b want 0 1", pulse, bus_a.req_ready); end
      do_access(0, 0, 3'b010, 32'h200, 32'h0, 32'hCAFEF00D, 32'h0, 0, r);
      total++; if (r.lat !== 3 || r.rdata !== 32'hCAFEF00D || r.addr0 !== 32'h200) begin bad++;
         $display("FAIL rstmid_next: lat=%0d rdata=%h addr=%h want 3 cafef00d 00000200", r.lat, r.rdata, r.addr0); end
   endtask

   task automatic test_back_to_back();
      res_t r1, r2;
      do_access(0, 0, 3'b010, 32'h300, 32'h0, 32'h01020304, 32'h0, 0, r1);
      do_access(0, 0, 3'b010, 32'h304, 32'h0, 32'h05060708, 32'h0, 0, r2);
      total++; if (r2.rdy !== 1'b1 || (r2.acc - r1.acc) !== 4) begin bad++;
         $display("FAIL b2b_spacing: ready=%b spacing=%0d want 1 4", r2.rdy, r2.acc - r1.acc); end
      total++; if (r1.rdata !== 32'h01020304 || r2.rdata !== 32'h05060708) begin bad++;
         $display("FAIL b2b_data: got %h %h want 01020304 05060708", r1.rdata, r2.rdata); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; sel_v = 1'b0; valid_v = 1'b0; we_v = 1'b0; gnt_v = 1'b0; rv_v = 1'b0;
      f3_v = 3'b0; addr_v = '0; wdata_v = '0; rd_v = '0;
      test_reset();
      test_aligned_load();
      test_store();
      test_split();
      test_errors();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
